// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous FIFO family.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and entry count
//   cnt_width()                   : occupancy counter width, wide enough to hold 0..depth
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // One bit more than the pointer so that a completely full FIFO (count == depth) fits.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: DEPTH x WIDTH, synchronous write, asynchronous read.
// Contents are deliberately not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module fifo_mem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with occupancy count, threshold flags and
// rejected-access error pulses. FWFT selects standard (registered, 1-cycle) or
// first-word-fall-through read data.
//   clk, rst              : clock, asynchronous active-high reset
//   wr_en, wdata          : write request and data
//   rd_en                 : read request (FWFT: pop of the presented word)
//   rdata                 : read data
//   full, empty           : count == DEPTH / count == 0
//   almost_full           : count >= AF_LEVEL
//   almost_empty          : count <= AE_LEVEL
//   count                 : current occupancy, 0..DEPTH
//   wr_err, rd_err        : one-cycle pulse after a rejected write / read
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter  int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter  int unsigned AF_LEVEL  = DEPTH - 2,
  parameter  int unsigned AE_LEVEL  = 2,
  parameter  int unsigned FWFT      = 0,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH),
  localparam int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wr_err,
  output logic                 rd_err
);

  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 wr_err_q, rd_err_q;
  logic                 wr_accept, rd_accept;
  logic [WIDTH-1:0]     mem_rdata;

  // Flags come straight from the registered count, so they reflect pre-edge state.
  assign full         = (count_q == CNT_WIDTH'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_WIDTH'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_WIDTH'(AE_LEVEL));
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

  // A full FIFO still accepts the read of a simultaneous pair; the write is dropped.
  assign wr_accept = wr_en & ~full;
  assign rd_accept = rd_en & ~empty;

  always_comb begin
    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (rd_accept) rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      count_q  <= count_d;
      wr_err_q <= wr_en & full;
      rd_err_q <= rd_en & empty;
    end
  end

  // The memory has no reset of its own, so block writes while rst is held.
  fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(PTR_WIDTH)
  ) u_fifo_mem (
    .clk  (clk),
    .we   (wr_accept & ~rst),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(mem_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Head word is always on the output; meaningless while empty.
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_accept) begin
        rdata_q <= mem_rdata;
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: one standard-read and one FWFT instance share stimulus.
// A queue-based reference model predicts occupancy, flags and error pulses; read
// words are pushed to scoreboards and checked by a separate monitor process.
module tb_param_sync_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 14;
  localparam int unsigned AE = 2;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  wdata = '0;

  logic [W-1:0]  rdata0, rdata1;
  logic          full0, empty0, afull0, aempty0, wr_err0, rd_err0;
  logic          full1, empty1, afull1, aempty1, wr_err1, rd_err1;
  logic [CW-1:0] count0, count1;

  int checks = 0;
  int errors = 0;

  // Reference model: stored words, and words already popped awaiting comparison.
  int model[$];
  int exp_q0[$];
  int exp_q1[$];
  bit exp_wr_err = 1'b0;
  bit exp_rd_err = 1'b0;

  always #5 clk = ~clk;

  param_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
  ) u_dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata0),
    .full(full0), .empty(empty0), .almost_full(afull0), .almost_empty(aempty0),
    .count(count0), .wr_err(wr_err0), .rd_err(rd_err0)
  );

  param_sync_fifo #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
  ) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .rdata(rdata1),
    .full(full1), .empty(empty1), .almost_full(afull1), .almost_empty(aempty1),
    .count(count1), .wr_err(wr_err1), .rd_err(rd_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = model.size();
    chk("count_std",     32'(count0), 32'(sz));
    chk("count_fwft",    32'(count1), 32'(sz));
    chk("full_std",      32'(full0),   32'(sz == D));
    chk("full_fwft",     32'(full1),   32'(sz == D));
    chk("empty_std",     32'(empty0),  32'(sz == 0));
    chk("empty_fwft",    32'(empty1),  32'(sz == 0));
    chk("afull_std",     32'(afull0),  32'(sz >= AF));
    chk("afull_fwft",    32'(afull1),  32'(sz >= AF));
    chk("aempty_std",    32'(aempty0), 32'(sz <= AE));
    chk("aempty_fwft",   32'(aempty1), 32'(sz <= AE));
    chk("wr_err_std",    32'(wr_err0), 32'(exp_wr_err));
    chk("wr_err_fwft",   32'(wr_err1), 32'(exp_wr_err));
    chk("rd_err_std",    32'(rd_err0), 32'(exp_rd_err));
    chk("rd_err_fwft",   32'(rd_err1), 32'(exp_rd_err));
  endtask

  // Checks the result of the previous edge, then drives the next cycle's request
  // and advances the model as the coming edge should.
  task automatic step(input bit we, input logic [W-1:0] wd, input bit re);
    int sz;
    @(posedge clk);
    #1;
    check_state();
    wr_en = we;
    wdata = wd;
    rd_en = re;
    sz = model.size();
    exp_wr_err = we && (sz == D);
    exp_rd_err = re && (sz == 0);
    if (re && sz > 0) begin
      int w;
      w = model.pop_front();
      exp_q0.push_back(w);
      exp_q1.push_back(w);
    end
    if (we && sz < D) model.push_back(int'(wd));
  endtask

  task automatic check_reset_outputs();
    chk("rst_count_std",  32'(count0),  0);
    chk("rst_count_fwft", 32'(count1),  0);
    chk("rst_empty_std",  32'(empty0),  1);
    chk("rst_aempty_std", 32'(aempty0), 1);
    chk("rst_full_std",   32'(full0),   0);
    chk("rst_afull_std",  32'(afull0),  0);
    chk("rst_errs_std",   32'({wr_err0, rd_err0}), 0);
    chk("rst_empty_fwft", 32'(empty1),  1);
    chk("rst_errs_fwft",  32'({wr_err1, rd_err1}), 0);
    chk("rst_rdata_std",  32'(rdata0),  0);
  endtask

  // Asynchronous reset asserted between edges; outputs must respond without a clock.
  task automatic mid_reset();
    step(1'b0, '0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model.delete();
    exp_q0.delete();
    exp_q1.delete();
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor. Standard read: data appears the cycle after an accepted
  // read edge. FWFT: the head word is on rdata before the edge that pops it.
  initial begin : monitor
    bit pending0;
    pending0 = 1'b0;
    forever begin
      @(negedge clk);
      if (pending0) begin
        if (exp_q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_std: got %0h, expected no read word", rdata0);
        end else begin
          chk("rdata_std", 32'(rdata0), 32'(exp_q0.pop_front()));
        end
      end
      pending0 = !rst && rd_en && !empty0;
      if (!rst && rd_en && !empty1) begin
        if (exp_q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rdata_fwft: got %0h, expected no read word", rdata1);
        end else begin
          chk("rdata_fwft", 32'(rdata1), 32'(exp_q1.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    repeat (2) step(1'b0, '0, 1'b0);

    // Fill 0x01..0x10, then one overflowing write of 0xFF.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, '0, 1'b0);

    // Drain all 16 plus one underflowing read.
    for (int i = 0; i < 17; i++) step(1'b0, '0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0);

    // FWFT: written word falls through with no read request.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("fwft_head", 32'(rdata1), 32'h0000_00A5);
    chk("fwft_not_empty", 32'(empty1), 0);
    step(1'b0, '0, 1'b1);
    repeat (2) step(1'b0, '0, 1'b0);

    // Simultaneous full at the full boundary: read wins, write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, W'(8'h80 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
    // Simultaneous at empty: write accepted, read rejected.
    step(1'b1, 8'h5A, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Steady streaming from count 8 across several pointer wraps.
    for (int i = 0; i < 8; i++) step(1'b1, W'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, W'(8'h40 + i), 1'b1);
    step(1'b0, '0, 1'b0);
    chk("stream_count", 32'(count0), 8);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Randomised traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 400; i++) begin
      int pw, pr;
      pw = ((i / 50) % 2 == 0) ? 75 : 30;
      pr = ((i / 50) % 2 == 0) ? 40 : 70;
      step($urandom_range(0, 99) < pw, W'($urandom), $urandom_range(0, 99) < pr);
    end
    while (model.size() > 0) step(1'b0, '0, 1'b1);

    // Reset with five words stored, then confirm the FIFO restarts cleanly.
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h60 + i), 1'b0);
    mid_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("post_rst_fwft_head", 32'(rdata1), 32'h0000_003C);
    step(1'b0, '0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    chk("post_rst_rdata_std", 32'(rdata0), 32'h0000_003C);

    chk("scoreboard_std_drained",  32'(exp_q0.size()), 0);
    chk("scoreboard_fwft_drained", 32'(exp_q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
